instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch front end feeding 32-bit RV32I instructions to the decode/control stage over a valid/ready handshake, the producer side of the instruction word the control decoder consumes. Issues one-outstanding requests to a variable-latency instruction memory, prefetches into a 2-entry instruction queue, flushes on branch/jump redirects, and stops fetching at ECALL, raising `is_halted` once the ECALL is consumed.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` input 1, single clock, rising edge
- `reset_n` input 1, asynchronous, active-low reset
- `imem_req` output 1, fetch request, registered
- `imem_addr` output 32, fetch address, registered, bits [1:0] always 0
- `imem_ack` input 1, request accepted and `imem_rdata` valid this cycle
- `imem_rdata` input 32, instruction word
- `inst_valid` output 1, queue head valid
- `inst` output 32, queue head instruction
- `inst_pc` output 32, PC of queue head
- `inst_ready` input 1, decode accepts head this cycle
- `redirect_valid` input 1, taken branch/JAL/JALR resolved this cycle
- `redirect_pc` input 32, redirect target; bits [1:0] ignored
- `is_halted` output 1, ECALL consumed; sticky until reset

## Operation
- State: `fetch_pc`, `in_flight`, `discard`, `stop` (ECALL enqueued), `halted`, 2-entry queue of {inst, pc} with 2-bit count.
- Issue rule: a request goes out in cycle t+1 when, at end of cycle t, no request remains in flight, `stop`=0, `halted`=0, and post-update queue count plus in-flight is below 2. `fetch_pc` advances by 4 per issued request (32-bit wrap).
- Memory handshake: `imem_req`/`imem_addr` held stable until the cycle `imem_ack`=1; ack may arrive in the first request cycle. Back-to-back requests allowed (req stays high, new address next cycle).
- Enqueue: on ack with `discard`=0, {imem_rdata, request addr} written at end of cycle. If opcode [6:0] = 7'b1110011 (ECALL), set `stop`.
- Dequeue: `inst_valid & inst_ready` pops head. Enqueue and dequeue in the same cycle keep count; enqueue into a full queue cannot occur (issue rule).
- Halt: dequeue of ECALL with `redirect_valid`=0 sets `halted`; `imem_req` forced 0 thereafter, `inst_valid` forced 0, queue cleared.
- Redirect (cycle t, not halted): queue flushed, `stop` cleared, `fetch_pc` <= {redirect_pc[31:2],2'b00}. Request in flight not acked in t: `discard` set, its data dropped on ack. Ack in t: data dropped. Handshake completing in t is treated as accepted but an ECALL accepted in t does not halt. Redirects while halted ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `is_halted`=0; queue empty, flags 0.
- First rising edge after `reset_n` deasserts: `imem_req`=1, `imem_addr`=RESET_PC.
- Ack in cycle k -> `inst_valid`=1 in cycle k+1 (no combinational memory-to-decode path).
- Redirect in t with nothing in flight -> `imem_req`=1 at target in t+1; with request in flight acked at k≥t -> target request in k+1.
- `is_halted` rises the cycle after ECALL handshake.
- Reset asserted mid-transaction: all state cleared immediately; outstanding request abandoned.

## Structure
- Shared package/header (`opcodes.v`): reuse `ECALL` opcode constant; add `INST_Q_DEPTH`=2.
- One natural sub-module: `inst_queue` (2-entry FIFO with flush, count, simultaneous push/pop).

## Test plan
- Reset release, memory ack latency 0, `inst_ready`=1: requests 0x0,0x4,0x8 back-to-back; `inst_pc` sequence 0x0,0x4,0x8 starting cycle 2.
- `inst_ready`=0, ack latency 1: exactly two instructions queued, `imem_req` low afterwards; raising ready resumes at next sequential PC with no loss or duplication.
- Redirect to 0x100 while request at 0x8 in flight (ack 3 cycles later): 0x8 data dropped, next request 0x100 in cycle after ack, next `inst_pc`=0x100.
- Redirect same cycle as ack and as head handshake: acked data dropped, queue empty next cycle, fetch resumes at target.
- ECALL (0x00000073) at 0x10: no request beyond 0x14 (already issued), `is_halted`=1 one cycle after ECALL handshake, `imem_req` stays 0; later redirect ignored.
- Redirect in ECALL handshake cycle: no halt, fetch resumes at redirect target; `reset_n` pulsed mid-request returns all outputs to reset values.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-side constants and the queue entry bundle.
// Imported by the fetch unit and its instruction queue.
package instruction_fetch_unit_pkg;

   localparam logic [6:0] ECALL = 7'b1110011;
   localparam int INST_Q_DEPTH = 2;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic is_ecall(input logic [31:0] w);
      return w[6:0] == ECALL;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_inst_queue.sv
// Two-entry instruction FIFO with flush and simultaneous push/pop.
// Exposes the post-update count so the fetcher can plan its next issue.
module instruction_fetch_unit_inst_queue
   import instruction_fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t data_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o,
   output logic [1:0]   count_nxt_o
);

   fetch_entry_t mem_q [INST_Q_DEPTH];
   logic         head_q;
   logic [1:0]   cnt_q;
   logic [1:0]   cnt_d;
   logic         wr_idx;

   assign wr_idx  = head_q ^ cnt_q[0];
   assign head_o  = mem_q[head_q];
   assign count_o = cnt_q;
   assign count_nxt_o = cnt_d;

   always_comb begin
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      if (flush_i) begin
         cnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         if (flush_i) begin
            head_q <= 1'b0;
         end else begin
            if (push_i) begin
               mem_q[wr_idx] <= data_i;
            end
            if (pop_i) begin
               head_q <= ~head_q;
            end
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: one-outstanding imem requests, 2-deep prefetch,
// redirect flush and ECALL halt.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        is_halted
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        discard_q, discard_d;
   logic        stop_q, stop_d;
   logic        halted_q, halted_d;

   fetch_entry_t head, wr_ent;
   logic [1:0]   q_cnt, q_cnt_nxt;
   logic         ack, redir, pop, push;
   logic         halt_now, flush;
   logic         in_flight_nxt, stop_eff, issue;
   logic [31:0]  pc_eff;

   assign ack      = imem_ack & req_q & ~halted_q;
   assign redir    = redirect_valid & ~halted_q;
   assign pop      = inst_valid & inst_ready;
   assign halt_now = pop & is_ecall(head.inst)
                   & ~redirect_valid;
   assign push     = ack & ~discard_q & ~redir & ~halt_now;
   assign flush    = redir | halt_now;

   assign in_flight_nxt = req_q & ~ack;
   assign stop_eff      = stop_q & ~redir;
   assign pc_eff = redir ? (redirect_pc & ~32'h3) : fetch_pc_q;

   // Issue only when the queue will still have room for the reply.
   assign issue = ~in_flight_nxt & ~stop_eff & ~halted_q
                & ~halt_now & (q_cnt_nxt < 2'(INST_Q_DEPTH));

   assign wr_ent.inst = imem_rdata;
   assign wr_ent.pc   = addr_q;

   instruction_fetch_unit_inst_queue u_queue (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush_i     (flush),
      .push_i      (push),
      .pop_i       (pop),
      .data_i      (wr_ent),
      .head_o      (head),
      .count_o     (q_cnt),
      .count_nxt_o (q_cnt_nxt)
   );

   always_comb begin
      fetch_pc_d = pc_eff;
      req_d      = in_flight_nxt;
      addr_d     = addr_q;
      discard_d  = discard_q;
      stop_d     = stop_q;
      halted_d   = halted_q | halt_now;
      if (issue) begin
         req_d      = 1'b1;
         addr_d     = pc_eff;
         fetch_pc_d = pc_eff + 32'd4;
      end
      if (halt_now) begin
         req_d = 1'b0;
      end
      if (ack) begin
         discard_d = 1'b0;
      end else if (redir && req_q) begin
         discard_d = 1'b1;
      end
      if (redir) begin
         stop_d = 1'b0;
      end else if (push && is_ecall(imem_rdata)) begin
         stop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
         discard_q  <= 1'b0;
         stop_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
         discard_q  <= discard_d;
         stop_q     <= stop_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_req   = req_q & ~halted_q;
   assign imem_addr  = addr_q;
   assign inst_valid = (q_cnt != 2'd0) & ~halted_q;
   assign inst       = head.inst;
   assign inst_pc    = head.pc;
   assign is_halted  = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: program-stream scoreboard with
// random latency/ready/redirects plus directed scenarios.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        is_halted;

   instruction_fetch_unit dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .is_halted      (is_halted)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc, lat, lat_fix, ready_mode;
   int          req_cnt, hs_cnt;
   bit          pend, redir_en, force_redir;
   bit          model_halted, halt_next;
   logic [31:0] pend_addr, slow_addr, force_target;
   logic [31:0] exp_pc, exp_fetch, ecall_addr, last_req;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d got %h exp %h",
                  tag, cyc, got, exp);
      end
   endtask

   // Program image: ADDI-like words, one ECALL at ecall_addr.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == ecall_addr) return 32'h0000_0073;
      return {a[26:2] ^ 25'h15a_5a5a, 7'b0010011};
   endfunction

   task automatic step();
      logic [31:0] tgt;
      @(negedge clk);
      cyc++;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (imem_req) begin
         if (!pend) begin
            chk("req_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            pend      = 1'b1;
            pend_addr = imem_addr;
            last_req  = imem_addr;
            req_cnt++;
            if (imem_addr == slow_addr) lat = 3;
            else if (lat_fix < 0) lat = $urandom_range(0, 3);
            else lat = lat_fix;
         end else begin
            chk("addr_hold", imem_addr, pend_addr);
         end
         if (lat == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            pend       = 1'b0;
         end else begin
            lat--;
         end
      end else begin
         pend = 1'b0;
      end
      if (halt_next) model_halted = 1'b1;
      halt_next = 1'b0;
      chk("halted", {31'b0, is_halted}, {31'b0, model_halted});
      if (model_halted) begin
         chk("req_off", {31'b0, imem_req}, 32'd0);
         chk("valid_off", {31'b0, inst_valid}, 32'd0);
      end
      if (ready_mode == 2) inst_ready = 1'($urandom_range(0, 1));
      else inst_ready = (ready_mode == 1);
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_target;
         force_redir    = 1'b0;
      end else if (redir_en && $urandom_range(0, 31) == 0) begin
         tgt = {$urandom_range(16, 31), 2'b00};
         redirect_valid = 1'b1;
         redirect_pc    = tgt | 32'($urandom_range(0, 3));
      end
      if (inst_valid && inst_ready) begin
         chk("hs_pc", inst_pc, exp_pc);
         chk("hs_inst", inst, mem_word(exp_pc));
         hs_cnt++;
         if (exp_pc == ecall_addr && !redirect_valid)
            halt_next = 1'b1;
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid && !model_halted) begin
         exp_pc    = redirect_pc & ~32'h3;
         exp_fetch = redirect_pc & ~32'h3;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      reset_n        = 1'b0;
      imem_ack       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_pc", inst_pc, 32'h0);
      chk("rst_halt", {31'b0, is_halted}, 32'd0);
      pend = 0; model_halted = 0; halt_next = 0;
      force_redir = 0; req_cnt = 0; hs_cnt = 0;
      exp_pc = 32'h0; exp_fetch = 32'h0; cyc = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic mode(input int lf, input int rm,
                       input logic [31:0] ea);
      lat_fix    = lf;
      ready_mode = rm;
      ecall_addr = ea;
      redir_en   = 1'b0;
      slow_addr  = 32'hffff_ffff;
   endtask

   initial begin
      mode(0, 1, 32'hffff_fff0);
      do_reset();

      // back-to-back fetch with zero-latency memory
      step();
      chk("t1_req", {31'b0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'h0);
      chk("t1_v1", {31'b0, inst_valid}, 32'd0);
      step();
      chk("t1_v2", {31'b0, inst_valid}, 32'd1);
      chk("t1_pc2", inst_pc, 32'h0);
      step();
      chk("t1_pc3", inst_pc, 32'h4);
      step();
      chk("t1_pc4", inst_pc, 32'h8);

      // stalled decode fills the queue then fetch stops
      mode(1, 0, 32'hffff_fff0);
      do_reset();
      run(10);
      chk("t2_reqs", req_cnt, 2);
      chk("t2_req_low", {31'b0, imem_req}, 32'd0);
      chk("t2_valid", {31'b0, inst_valid}, 32'd1);
      chk("t2_head", inst_pc, 32'h0);
      ready_mode = 1;
      run(12);
      chk("t2_resume", {31'b0, hs_cnt >= 5}, 32'd1);

      // redirect while 0x8 is outstanding for three cycles
      mode(0, 1, 32'hffff_fff0);
      slow_addr = 32'h8;
      do_reset();
      run(2);
      force_redir  = 1'b1;
      force_target = 32'h100;
      run(4);
      chk("t3_idle", {31'b0, inst_valid}, 32'd0);
      step();
      chk("t3_req", {31'b0, imem_req}, 32'd1);
      chk("t3_addr", imem_addr, 32'h100);
      chk("t3_drop", {31'b0, inst_valid}, 32'd0);
      step();
      chk("t3_valid", {31'b0, inst_valid}, 32'd1);
      chk("t3_pc", inst_pc, 32'h100);

      // redirect coinciding with ack and head handshake
      mode(0, 1, 32'hffff_fff0);
      do_reset();
      step();
      force_redir  = 1'b1;
      force_target = 32'h203;
      step();
      step();
      chk("t4_empty", {31'b0, inst_valid}, 32'd0);
      chk("t4_req", {31'b0, imem_req}, 32'd1);
      chk("t4_addr", imem_addr, 32'h200);
      step();
      chk("t4_pc", inst_pc, 32'h200);

      // ECALL at 0x10 halts the front end
      mode(0, 1, 32'h10);
      do_reset();
      run(6);
      chk("t5_pre", {31'b0, is_halted}, 32'd0);
      step();
      chk("t5_halt", {31'b0, is_halted}, 32'd1);
      chk("t5_last", last_req, 32'h14);
      chk("t5_reqs", req_cnt, 6);
      force_redir  = 1'b1;
      force_target = 32'h40;
      run(8);
      chk("t5_stay", {31'b0, is_halted}, 32'd1);
      chk("t5_noreq", req_cnt, 6);

      // redirect during ECALL handshake, then reset mid-request
      mode(0, 1, 32'h10);
      slow_addr = 32'h40;
      do_reset();
      run(5);
      force_redir  = 1'b1;
      force_target = 32'h40;
      run(2);
      chk("t6_nohalt", {31'b0, is_halted}, 32'd0);
      chk("t6_req", {31'b0, imem_req}, 32'd1);
      chk("t6_addr", imem_addr, 32'h40);
      do_reset();
      run(3);

      // random latency, ready and redirects until ECALL halts
      for (int s = 0; s < 8; s++) begin
         mode(-1, 2, 32'h80);
         redir_en = 1'b1;
         do_reset();
         for (int c = 0; c < 3000 && !model_halted; c++) step();
         chk("rnd_halt", {31'b0, is_halted}, 32'd1);
         run(6);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
